// File: rtl/pipelined_logical_reduce_pkg.sv
`default_nettype none
// ============================================================================
// Module   : logical_reduce_pkg
// Purpose  : Shared types and elaboration helpers for the pipelined reducer.
// Revision : 1.0 - initial release
// ============================================================================
package logical_reduce_pkg;

   typedef enum logic [1:0] {
      LR_OR   = 2'b00,
      LR_AND  = 2'b01,
      LR_XOR  = 2'b10,
      LR_XNOR = 2'b11
   } lr_op_t;

   // Pipeline depth: enough radix-RADIX OR levels to fold N bits down to one.
   function automatic int lr_levels(input int n, input int radix);
      int bits_n;
      int bits_r;
      int lv;
      bits_n = $clog2(n);
      bits_r = $clog2(radix);
      lv     = (bits_n + bits_r - 1) / bits_r;
      return (lv < 1) ? 1 : lv;
   endfunction

   function automatic int lr_width(input int n, input int radix, input int k);
      int w;
      w = n;
      for (int i = 0; i < k; i++) begin
         w = (w + radix - 1) / radix;
      end
      return w;
   endfunction

   function automatic logic lr_apply(input lr_op_t op, input logic x, input logic y);
      case (op)
         LR_OR:   return x | y;
         LR_AND:  return x & y;
         LR_XOR:  return x ^ y;
         default: return ~(x ^ y);
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/pipelined_logical_reduce_if.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_logical_reduce_if
// Purpose  : Operand/result valid-ready bundle for the pipelined reducer.
// Revision : 1.0 - initial release
// ============================================================================
interface pipelined_logical_reduce_if
   import logical_reduce_pkg::*;
#(
   parameter int N     = 8,
   parameter int TAG_W = 4
);

   logic             in_valid;
   logic             in_ready;
   logic [N-1:0]     a;
   logic [N-1:0]     b;
   lr_op_t           op;
   logic [TAG_W-1:0] tag;
   logic             out_valid;
   logic             out_ready;
   logic             c;
   logic [TAG_W-1:0] out_tag;

   modport master (
      output in_valid, a, b, op, tag, out_ready,
      input  in_ready, out_valid, c, out_tag
   );

   modport slave (
      input  in_valid, a, b, op, tag, out_ready,
      output in_ready, out_valid, c, out_tag
   );

endinterface
`default_nettype wire

// File: rtl/pipelined_logical_reduce_stage.sv
`default_nettype none
// ============================================================================
// Module   : reduce_stage
// Purpose  : One group-OR level with a valid/ready register slice; the last
//            level also folds the two truth bits through the selected op.
// Revision : 1.0 - initial release
// ============================================================================
module reduce_stage
   import logical_reduce_pkg::*;
#(
   parameter  int IN_W  = 8,
   parameter  int RADIX = 4,
   parameter  int TAG_W = 4,
   parameter  bit LAST  = 1'b0,
   localparam int OUT_W = (IN_W + RADIX - 1) / RADIX
) (
   input  wire              clk,
   input  wire              rst_n,
   input  wire              i_valid,
   output logic             o_ready,
   input  wire  [IN_W-1:0]  i_pa,
   input  wire  [IN_W-1:0]  i_pb,
   input  wire  lr_op_t     i_op,
   input  wire  [TAG_W-1:0] i_tag,
   output logic             o_valid,
   input  wire              i_ready,
   output logic [OUT_W-1:0] o_pa,
   output logic [OUT_W-1:0] o_pb,
   output lr_op_t           o_op,
   output logic [TAG_W-1:0] o_tag,
   output logic             o_c
);

   localparam int PAD_W = OUT_W * RADIX;

   logic             r_valid;
   logic [OUT_W-1:0] r_pa;
   logic [OUT_W-1:0] r_pb;
   lr_op_t           r_op;
   logic [TAG_W-1:0] r_tag;

   logic             w_ready;
   logic [PAD_W-1:0] w_pad_a;
   logic [PAD_W-1:0] w_pad_b;
   logic [OUT_W-1:0] w_grp_a;
   logic [OUT_W-1:0] w_grp_b;

   // An empty slot, or one whose beat leaves this edge, can take a new beat.
   assign w_ready = !r_valid || i_ready;

   generate
      if (PAD_W > IN_W) begin : g_pad
         assign w_pad_a = {{(PAD_W - IN_W){1'b0}}, i_pa};
         assign w_pad_b = {{(PAD_W - IN_W){1'b0}}, i_pb};
      end else begin : g_nopad
         assign w_pad_a = i_pa;
         assign w_pad_b = i_pb;
      end
   endgenerate

   always_comb begin
      w_grp_a = '0;
      w_grp_b = '0;
      for (int j = 0; j < OUT_W; j++) begin
         w_grp_a[j] = |w_pad_a[j*RADIX +: RADIX];
         w_grp_b[j] = |w_pad_b[j*RADIX +: RADIX];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_pa    <= '0;
         r_pb    <= '0;
         r_op    <= LR_OR;
         r_tag   <= '0;
      end else if (w_ready) begin
         r_valid <= i_valid;
         r_pa    <= w_grp_a;
         r_pb    <= w_grp_b;
         r_op    <= i_op;
         r_tag   <= i_tag;
      end
   end

   generate
      if (LAST) begin : g_last
         logic r_c;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_c <= 1'b0;
            end else if (w_ready) begin
               r_c <= lr_apply(i_op, w_grp_a[0], w_grp_b[0]);
            end
         end

         assign o_c = r_c;
      end else begin : g_mid
         assign o_c = 1'b0;
      end
   endgenerate

   assign o_ready = w_ready;
   assign o_valid = r_valid;
   assign o_pa    = r_pa;
   assign o_pb    = r_pb;
   assign o_op    = r_op;
   assign o_tag   = r_tag;

endmodule
`default_nettype wire

// File: rtl/pipelined_logical_reduce.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_logical_reduce
// Purpose  : Pipelined "any bit set" reducer of two operands combined by a
//            selectable logical op, with valid/ready flow control and a tag.
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_logical_reduce
   import logical_reduce_pkg::*;
#(
   parameter int N     = 8,
   parameter int RADIX = 4,
   parameter int TAG_W = 4
) (
   input wire clk,
   input wire rst_n,
   pipelined_logical_reduce_if.slave bus
);

   localparam int LEVELS = lr_levels(N, RADIX);

   generate
      for (genvar k = 0; k < LEVELS; k++) begin : g_stage
         localparam int IN_W  = lr_width(N, RADIX, k);
         localparam int OUT_W = lr_width(N, RADIX, k + 1);

         logic             w_in_valid;
         logic [IN_W-1:0]  w_in_pa;
         logic [IN_W-1:0]  w_in_pb;
         lr_op_t           w_in_op;
         logic [TAG_W-1:0] w_in_tag;
         logic             w_dn_ready;
         logic             w_ready;
         logic             w_valid;
         logic [OUT_W-1:0] w_pa;
         logic [OUT_W-1:0] w_pb;
         lr_op_t           w_op;
         logic [TAG_W-1:0] w_tag;
         logic             w_c;

         if (k == 0) begin : g_head
            assign w_in_valid   = bus.in_valid;
            assign w_in_pa      = bus.a;
            assign w_in_pb      = bus.b;
            assign w_in_op      = bus.op;
            assign w_in_tag     = bus.tag;
            assign bus.in_ready = w_ready;
         end else begin : g_body
            assign w_in_valid = g_stage[k-1].w_valid;
            assign w_in_pa    = g_stage[k-1].w_pa;
            assign w_in_pb    = g_stage[k-1].w_pb;
            assign w_in_op    = g_stage[k-1].w_op;
            assign w_in_tag   = g_stage[k-1].w_tag;
         end

         // Ready ripples back combinationally so bubbles collapse in one cycle.
         if (k == LEVELS - 1) begin : g_tail
            logic w_tail_unused;
            assign w_dn_ready    = bus.out_ready;
            assign bus.out_valid = w_valid;
            assign bus.c         = w_c;
            assign bus.out_tag   = w_tag;
            assign w_tail_unused = ^{w_pa, w_pb, w_op};
         end else begin : g_link
            logic w_c_unused;
            assign w_dn_ready = g_stage[k+1].w_ready;
            assign w_c_unused = w_c;
         end

         reduce_stage #(
            .IN_W  (IN_W),
            .RADIX (RADIX),
            .TAG_W (TAG_W),
            .LAST  (k == LEVELS - 1)
         ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_valid (w_in_valid),
            .o_ready (w_ready),
            .i_pa    (w_in_pa),
            .i_pb    (w_in_pb),
            .i_op    (w_in_op),
            .i_tag   (w_in_tag),
            .o_valid (w_valid),
            .i_ready (w_dn_ready),
            .o_pa    (w_pa),
            .o_pb    (w_pb),
            .o_op    (w_op),
            .o_tag   (w_tag),
            .o_c     (w_c)
         );
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pipelined_logical_reduce.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_logical_reduce
// Purpose  : Self-checking bench for pipelined_logical_reduce (two configs).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipelined_logical_reduce;
   import logical_reduce_pkg::*;

   localparam int N_A      = 8;
   localparam int RADIX_A  = 2;
   localparam int LEVELS_A = 3;
   localparam int N_B      = 10;
   localparam int RADIX_B  = 4;
   localparam int LEVELS_B = 2;
   localparam int TAG_W    = 4;
   localparam int N_BEATS  = 10000;

   typedef struct {
      logic             c;
      logic [TAG_W-1:0] tag;
   } beat_t;

   logic clk;
   logic rst_n;

   pipelined_logical_reduce_if #(.N(N_A), .TAG_W(TAG_W)) bus_a ();
   pipelined_logical_reduce_if #(.N(N_B), .TAG_W(TAG_W)) bus_b ();

   pipelined_logical_reduce #(.N(N_A), .RADIX(RADIX_A), .TAG_W(TAG_W)) u_dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_a)
   );

   pipelined_logical_reduce #(.N(N_B), .RADIX(RADIX_B), .TAG_W(TAG_W)) u_dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   // Reference: each operand collapses to "is it nonzero", then the op applies.
   function automatic logic ref_c(input logic [31:0] a, input logic [31:0] b, input int op);
      logic x;
      logic y;
      x = (a != 0);
      y = (b != 0);
      case (op)
         0:       return x | y;
         1:       return x & y;
         2:       return x ^ y;
         default: return ~(x ^ y);
      endcase
   endfunction

   task automatic send_beat(input int sel, input logic [31:0] a, input logic [31:0] b,
                            input int op, input logic [TAG_W-1:0] tg, input string name);
      int   lat;
      logic ov;
      @(negedge clk);
      if (sel == 0) begin
         bus_a.a = a[N_A-1:0]; bus_a.b = b[N_A-1:0]; bus_a.op = lr_op_t'(2'(op));
         bus_a.tag = tg; bus_a.out_ready = 1'b1; bus_a.in_valid = 1'b1;
      end else begin
         bus_b.a = a[N_B-1:0]; bus_b.b = b[N_B-1:0]; bus_b.op = lr_op_t'(2'(op));
         bus_b.tag = tg; bus_b.out_ready = 1'b1; bus_b.in_valid = 1'b1;
      end
      #1;
      check({name, "_in_ready"}, (sel == 0) ? bus_a.in_ready : bus_b.in_ready, 1);
      @(posedge clk);
      @(negedge clk);
      bus_a.in_valid = 1'b0;
      bus_b.in_valid = 1'b0;
      lat = 1;
      ov  = (sel == 0) ? bus_a.out_valid : bus_b.out_valid;
      while (!ov && lat < 12) begin
         @(negedge clk);
         lat++;
         ov = (sel == 0) ? bus_a.out_valid : bus_b.out_valid;
      end
      check({name, "_latency"}, lat, (sel == 0) ? LEVELS_A : LEVELS_B);
      check({name, "_c"}, (sel == 0) ? bus_a.c : bus_b.c, ref_c(a, b, op));
      check({name, "_tag"}, (sel == 0) ? bus_a.out_tag : bus_b.out_tag, tg);
   endtask

   beat_t            exp_q[$];
   beat_t            got_b;
   int               sent;
   int               accepted;
   int               cycles;
   int               guard;
   int               first_out;
   int               last_out;
   int               n_out;
   int               order_bad;
   logic             stale;
   logic             stall_prev;
   logic             prev_c;
   logic [TAG_W-1:0] prev_tag;

   initial begin
      rst_n = 1'b0;
      bus_a.in_valid = 1'b0; bus_a.a = '0; bus_a.b = '0; bus_a.op = LR_OR;
      bus_a.tag = '0; bus_a.out_ready = 1'b1;
      bus_b.in_valid = 1'b0; bus_b.a = '0; bus_b.b = '0; bus_b.op = LR_OR;
      bus_b.tag = '0; bus_b.out_ready = 1'b1;

      #3;
      check("reset_out_valid", bus_a.out_valid, 0);
      check("reset_c", bus_a.c, 0);
      check("reset_out_tag", bus_a.out_tag, 0);
      check("reset_in_ready", bus_a.in_ready, 1);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Latency and op sweep on the 3-level configuration.
      send_beat(0, 32'h00, 32'h40, 0, 4'd5, "lat_or");
      send_beat(0, 32'h00, 32'h40, 1, 4'd5, "lat_and");
      for (int op = 0; op < 4; op++) send_beat(0, 32'h01, 32'h80, op, 4'(op), "sweep_set");
      for (int op = 0; op < 4; op++) send_beat(0, 32'h00, 32'h00, op, 4'(op + 8), "sweep_zero");

      // Zero-padded last group on the 10-bit, radix-4 configuration.
      send_beat(1, 32'h200, 32'h0, 0, 4'd3, "pad_hi");
      send_beat(1, 32'h000, 32'h0, 0, 4'd4, "pad_zero");
      send_beat(1, 32'h000, 32'h1, 3, 4'd6, "pad_xnor");

      // Back-pressure: fill with out_ready low, then release and drain in order.
      @(negedge clk);
      bus_a.out_ready = 1'b0;
      bus_a.a = 8'h01; bus_a.b = 8'h00; bus_a.op = LR_OR;
      sent = 0;
      for (int i = 0; i < 8; i++) begin
         bus_a.in_valid = 1'b1;
         bus_a.tag      = 4'(sent);
         #1;
         if (!bus_a.in_ready) break;
         @(posedge clk);
         sent++;
         @(negedge clk);
      end
      check("bp_accepts_before_full", sent, LEVELS_A);
      bus_a.out_ready = 1'b1;
      first_out = -1; last_out = -1; n_out = 0; order_bad = 0;
      for (int i = 0; i < 30 && n_out < 6; i++) begin
         bus_a.in_valid = (sent < 6);
         bus_a.tag      = 4'(sent);
         #1;
         if (bus_a.out_valid) begin
            if (bus_a.out_tag !== 4'(n_out)) order_bad++;
            if (first_out < 0) first_out = i;
            last_out = i;
            n_out++;
         end
         @(posedge clk);
         if (bus_a.in_valid && sent < 6) sent++;
         @(negedge clk);
      end
      bus_a.in_valid = 1'b0;
      check("bp_delivered", n_out, 6);
      check("bp_order", order_bad, 0);
      check("bp_no_gaps", last_out - first_out + 1, 6);

      // Asynchronous reset with two beats in flight.
      @(negedge clk);
      bus_a.out_ready = 1'b0;
      bus_a.a = 8'h10; bus_a.b = 8'h00; bus_a.op = LR_OR;
      bus_a.tag = 4'd7; bus_a.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus_a.tag = 4'd8;
      @(posedge clk);
      @(negedge clk);
      bus_a.in_valid = 1'b0;
      guard = 0;
      while (!bus_a.out_valid && guard < 10) begin
         @(negedge clk);
         guard++;
      end
      check("rst_pre_valid", bus_a.out_valid, 1);
      check("rst_pre_c", bus_a.c, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_async_out_valid", bus_a.out_valid, 0);
      check("rst_async_c", bus_a.c, 0);
      check("rst_async_out_tag", bus_a.out_tag, 0);
      check("rst_async_in_ready", bus_a.in_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      bus_a.out_ready = 1'b1;
      stale = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (bus_a.out_valid) stale = 1'b1;
      end
      check("rst_no_stale_beat", stale, 0);

      // Random traffic against the in-order scoreboard.
      accepted = 0; cycles = 0; stall_prev = 1'b0; prev_c = 1'b0; prev_tag = '0;
      while (accepted < N_BEATS && cycles < 60000) begin
         @(negedge clk);
         cycles++;
         if (stall_prev) begin
            check("stall_out_valid", bus_a.out_valid, 1);
            check("stall_c", bus_a.c, prev_c);
            check("stall_out_tag", bus_a.out_tag, prev_tag);
         end
         bus_a.in_valid  = ($urandom_range(0, 99) < 70);
         bus_a.a         = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
         bus_a.b         = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
         bus_a.op        = lr_op_t'(2'($urandom_range(0, 3)));
         bus_a.tag       = 4'($urandom);
         bus_a.out_ready = ($urandom_range(0, 99) < 65);
         #1;
         check("rand_in_ready", bus_a.in_ready,
               ((exp_q.size() < LEVELS_A) || bus_a.out_ready) ? 1 : 0);
         if (bus_a.out_valid && bus_a.out_ready) begin
            if (exp_q.size() == 0) begin
               check("rand_spurious_beat", 1, 0);
            end else begin
               got_b = exp_q.pop_front();
               check("rand_c", bus_a.c, got_b.c);
               check("rand_tag", bus_a.out_tag, got_b.tag);
            end
         end
         stall_prev = bus_a.out_valid && !bus_a.out_ready;
         prev_c     = bus_a.c;
         prev_tag   = bus_a.out_tag;
         if (bus_a.in_valid && bus_a.in_ready) begin
            exp_q.push_back('{c: ref_c(32'(bus_a.a), 32'(bus_a.b), int'(bus_a.op)),
                              tag: bus_a.tag});
            accepted++;
         end
      end
      check("rand_beats_accepted", accepted, N_BEATS);

      @(negedge clk);
      bus_a.in_valid  = 1'b0;
      bus_a.out_ready = 1'b1;
      guard = 0;
      while (exp_q.size() > 0 && guard < 20) begin
         #1;
         if (bus_a.out_valid) begin
            got_b = exp_q.pop_front();
            check("drain_c", bus_a.c, got_b.c);
            check("drain_tag", bus_a.out_tag, got_b.tag);
         end
         @(negedge clk);
         guard++;
      end
      check("drain_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout checks=%0d failures=%0d", n_checks, n_fail + 1);
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire

// File: doc/pipelined_logical_reduce.md
Name: pipelined_logical_reduce

Overview:
- Parametrised, pipelined successor to the structural two-operand logical reducer.
- Reduces two N-bit operands to single truth bits through a registered radix-RADIX OR tree, then combines them with a selectable logical op (OR/AND/XOR/XNOR).
- Carries a valid/ready handshake with full back-pressure and a pass-through tag.
- Sits between wide datapath compare logic and control FSMs that need a timing-clean "any bit set" decision.

Parameters:
- N, 8: operand width in bits; N >= 1.
- RADIX, 4: bits OR-reduced per group per stage; power of 2, >= 2.
- TAG_W, 4: width of the user tag carried alongside each transaction; >= 1.
- LEVELS (localparam), derived: max(1, ceil($clog2(N) / $clog2(RADIX))). This is the pipeline depth and latency.

Ports:
- clk, input, 1: single clock; all state on its rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: operand beat present.
- in_ready, output, 1: stage 0 can accept a beat.
- a, input, N: operand A.
- b, input, N: operand B.
- op, input, 2: 00 OR, 01 AND, 10 XOR, 11 XNOR, all applied to (|a, |b).
- tag, input, TAG_W: user tag, returned unchanged with the result.
- out_valid, output, 1: result beat present.
- out_ready, input, 1: downstream accepts the result.
- c, output, 1: logical result.
- out_tag, output, TAG_W: tag of the current result.

Behaviour:
- Reset: on assertion of rst_n=0, immediately and regardless of clk, clear every stage valid bit. Outputs during and after reset: out_valid=0, c=0, out_tag=0, in_ready=1. Data registers are also cleared, so no X appears on the outputs. Any beats in flight when reset is asserted are discarded, not completed.
- Stage k (k=0..LEVELS-1) holds:
  - valid_k;
  - the partial reductions pa_k and pb_k, each of width W_(k+1), where W_0=N and W_(k+1)=ceil(W_k/RADIX);
  - op_k and tag_k.
- Group reduction: each output bit j of a stage is the OR of input bits j*RADIX..j*RADIX+RADIX-1. Missing high bits in the last group are treated as 0 (zero-padded).
- Final stage: stage LEVELS-1 also applies op to its 1-bit pa and pb and registers the result as c. out_valid=valid_(LEVELS-1); out_tag=tag_(LEVELS-1).
- Handshake: a transfer occurs when valid && ready at a rising edge.
  - Per stage: ready_k = !valid_k || ready_(k+1), with ready_LEVELS = out_ready.
  - in_ready = ready_0, combinational through the chain. Bubbles collapse.
  - Stage k loads from upstream when ready_k is 1.
  - valid_k takes the upstream valid when ready_k is 1, and holds otherwise.
- Latency: exactly LEVELS cycles from the accepting edge to out_valid=1 when unstalled. Throughput is 1 beat per cycle.
- Stall: with out_ready=0, out_valid, c and out_tag stay stable until accepted. The pipeline fills to LEVELS beats, then in_ready=0. No beat is dropped or duplicated.
- Simultaneous events: when a full stage accepts a new beat on the same edge it hands its old beat downstream, the stage stays full with the new beat.
- Protocol rules:
  - Once out_valid=1, it stays 1 until the beat is accepted.
  - in_valid dropping without a transfer is legal, with no effect.
- N=1: LEVELS=1. The stage is a plain register plus the op.

Decomposition:
- Package logical_reduce_pkg:
  - enum lr_op_t {LR_OR=2'b00, LR_AND, LR_XOR, LR_XNOR};
  - function lr_levels(N, RADIX);
  - function lr_width(N, RADIX, k) returning W_k.
- Sub-module reduce_stage, parametrised by IN_W, RADIX, TAG_W and LAST:
  - contains the group-OR, the valid/ready register slice, and the op logic when LAST=1;
  - the top instantiates it LEVELS times in a generate loop.

Test Plan:
- Reset: N=8, RADIX=2, LEVELS=3; pulse rst_n low mid-pipeline with 2 beats in flight -> out_valid=0, c=0 and in_ready=1 immediately; no stale beat emerges afterwards.
- Latency: a=8'h00, b=8'h40, op=OR, tag=5, accepted at edge 0 -> out_valid=1 after edge 3 with c=1 and out_tag=5. The same beat with op=AND -> c=0.
- Op sweep: a=8'h01, b=8'h80 for each op -> OR 1, AND 1, XOR 0, XNOR 1. Then a=0, b=0 -> OR 0, AND 0, XOR 0, XNOR 1.
- Back-pressure: stream 6 beats with tags 0..5 while out_ready=0 -> in_ready falls after exactly 3 accepts. Releasing out_ready delivers tags 0..5 in order with no gaps, duplicates or losses.
- Zero-padding: N=10, RADIX=4 (LEVELS=2); a=10'h200, b=0, op=OR -> c=1 after 2 cycles; a=0 -> c=0.
- Random: 10k beats with random a, b, op and tag plus random in_valid/out_ready toggling -> results match a scoreboard model in order.
